// File: rtl/spi_master_tx_if.sv
// Byte handshake plus SPI pin bundle for spi_master_tx.
// master: the transmitter's view; slave: the byte source / pin observer.
interface spi_master_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       sck;
    logic       cs;
    logic       mosi;
    logic       busy;
    logic       done;

    modport master (
        input  tx_data, tx_valid,
        output tx_ready, sck, cs, mosi, busy, done
    );

    modport slave (
        output tx_data, tx_valid,
        input  tx_ready, sck, cs, mosi, busy, done
    );
endinterface

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter, MSB first, sck = clk / (2*CLK_DIV).
// Define SPI_TX_BURST_EN to let back-to-back bytes share one cs-low frame.
module spi_master_tx #(
    parameter int CLK_DIV = 8,
    parameter int CS_GAP  = 16
) (
    input  logic           clk,
    input  logic           reset,
    spi_master_tx_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_GAP} state_t;

    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             sck_q, sck_d;
    logic             cs_q, cs_d;
    logic             mosi_q, mosi_d;

    logic half_end;
    logic last_bit_end;
    logic tx_ready_c;
    logic accept;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        mosi_d   = mosi_q;

        half_end     = (cnt_q == DIV_LAST);
        last_bit_end = (state_q == S_HIGH) && (bit_q == 3'd0) && half_end;
`ifdef SPI_TX_BURST_EN
        tx_ready_c = !reset && ((state_q == S_IDLE) || last_bit_end);
`else
        tx_ready_c = !reset && (state_q == S_IDLE);
`endif
        accept = bus.tx_valid && tx_ready_c;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    bit_d   = 3'd7;
                    shift_d = bus.tx_data;
                    mosi_d  = bus.tx_data[7];
                end
            end
            S_SETUP, S_LOW: begin
                if (half_end) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HIGH: begin
                // mosi only ever moves together with the falling sck edge
                if (half_end) begin
                    cnt_d = '0;
                    if (bit_q != 3'd0) begin
                        state_d = S_LOW;
                        bit_d   = bit_q - 3'd1;
                        shift_d = {shift_q[6:0], 1'b0};
                        mosi_d  = shift_q[6];
                    end
`ifdef SPI_TX_BURST_EN
                    else if (accept) begin
                        state_d = S_LOW;
                        bit_d   = 3'd7;
                        shift_d = bus.tx_data;
                        mosi_d  = bus.tx_data[7];
                    end
`endif
                    else begin
                        state_d = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                // sck stays low with cs still asserted so the slave closes its byte
                if (half_end) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        sck_d = (state_d == S_HIGH);
        cs_d  = (state_d == S_IDLE) || (state_d == S_GAP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
        end
    end

    assign bus.tx_ready = tx_ready_c;
    assign bus.sck      = sck_q;
    assign bus.cs       = cs_q;
    assign bus.mosi     = mosi_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = last_bit_end;
endmodule
